// File: rtl/dff_arb_pkg.sv
// Shared types and index helpers for the round-robin write arbiter
// that fronts the shared D-register.
package dff_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Explicit modulo-n increment so non-power-of-2 requester counts wrap correctly.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dff_write_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first requester at or after ptr,
// scanning upward modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] win_o
);

  int j;

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid_o = 1'b0;
    win_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[IW'(j)]) begin
        valid_o = 1'b1;
        win_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write-side controller for a shared W-bit D-register, with
// optional bounded burst lock for a single owner.
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N*W-1:0]       d,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         q,
  output logic [$clog2(N)-1:0] q_owner,
  output logic                 q_upd
);

  localparam int IW = idx_w(N);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [W-1:0]  q_q;
  logic [IW-1:0] q_owner_q;
  logic          q_upd_q;

  logic          pick_valid;
  logic [IW-1:0] pick_win;
  logic          xfer;
  logic [IW-1:0] xfer_idx;
  logic [W-1:0]  wr_data;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .win_o   (pick_win)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    gnt      = '0;
    xfer     = 1'b0;
    xfer_idx = owner_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt[pick_win] = 1'b1;
            xfer          = 1'b1;
            xfer_idx      = pick_win;
            if (lock[pick_win] && (MAX_BURST > 1)) begin
              state_d = LOCKED;
              owner_d = pick_win;
              burst_d = BW'(1);
            end else begin
              ptr_d = IW'(wrap_inc(int'(pick_win), N));
            end
          end
        end
        LOCKED: begin
          // A dropped owner request costs one bubble cycle before re-arbitration.
          if (req[owner_q]) begin
            gnt[owner_q] = 1'b1;
            xfer         = 1'b1;
            burst_d      = burst_q + BW'(1);
            if (!lock[owner_q] || ((burst_q + BW'(1)) == BW'(MAX_BURST))) begin
              state_d = IDLE;
              ptr_d   = IW'(wrap_inc(int'(owner_q), N));
              burst_d = '0;
            end
          end else begin
            state_d = IDLE;
            ptr_d   = IW'(wrap_inc(int'(owner_q), N));
            burst_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // gnt is one-hot or zero, so an OR-free priority loop is a plain mux.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) wr_data = d[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      burst_q   <= '0;
      q_q       <= '0;
      q_owner_q <= '0;
      q_upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      q_upd_q <= xfer;
      if (xfer) begin
        q_q       <= wr_data;
        q_owner_q <= xfer_idx;
      end
    end
  end

  assign q       = q_q;
  assign q_owner = q_owner_q;
  assign q_upd   = q_upd_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Scoreboard bench for dff_write_arbiter: expected grants come from the
// stimulus plan, expected register contents are queued on each granted beat.
module tb_dff_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] d;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [1:0]     q_owner;
  logic           q_upd;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   owner;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  dff_write_arbiter #(
    .N         (N),
    .W         (W),
    .MAX_BURST (MB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .d       (d),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_upd   (q_upd)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_data(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) d[i*W +: W] = base + W'(i);
  endtask

  // One clock beat: inputs are already applied. Check the combinational grant,
  // queue the expected register update, then compare after the edge.
  task automatic beat(input logic [N-1:0] exp_gnt, input string nm);
    exp_t e;
    int   idx;
    #1;
    total_cnt++;
    if (gnt !== exp_gnt)
      $display("FAIL gnt_%s: got %b expected %b", nm, gnt, exp_gnt);
    else
      pass_cnt++;
    if (exp_gnt != '0) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (exp_gnt[i]) idx = i;
      e.data  = d[idx*W +: W];
      e.owner = 2'(idx);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    total_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (q_upd !== 1'b1 || q !== e.data || q_owner !== e.owner)
        $display("FAIL reg_%s: got upd=%b q=%h owner=%0d expected upd=1 q=%h owner=%0d",
                 nm, q_upd, q, q_owner, e.data, e.owner);
      else
        pass_cnt++;
    end else begin
      if (q_upd !== 1'b0)
        $display("FAIL upd_%s: got q_upd=%b expected 0", nm, q_upd);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b1111;
    lock = 4'b0000;
    set_data(8'h10);
    for (int c = 0; c < 2; c++) begin
      beat(4'b0000, "reset");
      total_cnt++;
      if (q !== 8'h00 || q_owner !== 2'd0)
        $display("FAIL reset_state: got q=%h owner=%0d expected q=00 owner=0", q, q_owner);
      else
        pass_cnt++;
    end
    rst = 1'b0;
    beat(4'b0001, "first_after_reset");
  endtask

  task automatic test_round_robin();
    beat(4'b0010, "rr1");
    beat(4'b0100, "rr2");
    beat(4'b1000, "rr3");
    beat(4'b0001, "rr_wrap");
  endtask

  task automatic test_sparse_wrap();
    req = 4'b0100;
    beat(4'b0100, "sparse_setup");
    req = 4'b0011;
    beat(4'b0001, "sparse_wrap0");
    beat(4'b0010, "sparse1");
    beat(4'b0001, "sparse0");
  endtask

  task automatic test_burst_cap();
    req  = 4'b0010;
    lock = 4'b0000;
    beat(4'b0010, "burst_setup");
    req  = 4'b0011;
    lock = 4'b0001;
    set_data(8'h20);
    for (int b = 0; b < MB; b++) begin
      d[0 +: W] = 8'h40 + W'(b);
      beat(4'b0001, $sformatf("burst_beat%0d", b));
    end
    beat(4'b0010, "burst_release");
    req  = 4'b0000;
    lock = 4'b0000;
    beat(4'b0000, "burst_idle");
  endtask

  task automatic test_early_exit();
    set_data(8'h30);
    req  = 4'b0100;
    lock = 4'b0100;
    beat(4'b0100, "drop_req_b1");
    beat(4'b0100, "drop_req_b2");
    req  = 4'b1011;
    lock = 4'b0000;
    beat(4'b0000, "drop_req_bubble");
    beat(4'b1000, "drop_req_next");
    req  = 4'b0100;
    lock = 4'b0100;
    beat(4'b0100, "drop_lock_b1");
    lock = 4'b0000;
    beat(4'b0100, "drop_lock_last");
    req  = 4'b1100;
    beat(4'b1000, "drop_lock_exit");
  endtask

  task automatic test_reset_mid_burst();
    set_data(8'h50);
    req  = 4'b0100;
    lock = 4'b0100;
    beat(4'b0100, "midrst_b1");
    req       = 4'b0110;
    d[2*W +: W] = 8'hAA;
    rst       = 1'b1;
    beat(4'b0000, "midrst_b2");
    total_cnt++;
    if (q === 8'hAA || q !== 8'h00)
      $display("FAIL midrst_q: got q=%h expected 00 (never AA)", q);
    else
      pass_cnt++;
    rst  = 1'b0;
    lock = 4'b0000;
    beat(4'b0010, "midrst_next");
    req = 4'b0000;
    beat(4'b0000, "drain");
    total_cnt++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
    else
      pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_sparse_wrap();
    test_burst_cap();
    test_early_exit();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
